// File: rtl/pio_arb_pkg.sv
// Shared definitions for the PIO node arbiter.
//   arb_state_t  : transaction FSM states (IDLE -> ACCESS -> ACK -> IDLE)
//   DEF_*        : default parameter values for the arbiter and its sub-blocks
package pio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_ADDR_W  = 2;

endpackage

// File: rtl/pio_node_arbiter_rr.sv
// Round-robin requester selection.
//   req        : request vector, one bit per requester
//   last_grant : index of the requester served most recently
//   grant      : first requester with req set, searching upward from
//                last_grant+1 and wrapping
//   valid      : at least one request is pending
module rr_arbiter
  import pio_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               valid
);

  logic [2*NUM_REQ-1:0] rotated;
  logic                 found;
  int unsigned          idx;

  // Duplicating the vector and shifting right puts requester last_grant+1
  // at bit 0, so a fixed low-to-high priority scan implements the rotation.
  always_comb begin
    rotated = {req, req} >> (32'(last_grant) + 32'd1);
    found   = 1'b0;
    grant   = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && rotated[k]) begin
        found = 1'b1;
        idx   = 32'(last_grant) + 32'd1 + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        grant = IDX_W'(idx);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/pio_node_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single Avalon PIO node slave.
// Each transaction takes three cycles: IDLE (grant + latch), ACCESS (one
// chipselect cycle), ACK (one-cycle ack pulse to the granted requester).
//   clk, reset_n      : clock, asynchronous active-low reset
//   req/req_write     : per-requester request and direction (1 = write)
//   req_addr/req_wdata: packed per-requester address and write data
//   ack               : completion pulse to the granted requester
//   rdata             : data of the last completed read
//   busy              : FSM not in IDLE
//   pio_*             : Avalon slave drive / read data of the PIO node
module pio_node_arbiter
  import pio_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         pio_address,
  output logic                      pio_chipselect,
  output logic                      pio_write_n,
  output logic [DATA_W-1:0]         pio_writedata,
  input  logic [DATA_W-1:0]         pio_readdata
);

  localparam int unsigned      IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  last_grant_q;
  logic [IDX_W-1:0]  grant_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [IDX_W-1:0]  arb_grant;
  logic              arb_valid;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  // Select the granted requester's direction, address and data slice.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(arb_grant) == i) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_valid) state_d = ACCESS;
      ACCESS:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction datapath: latch on grant, capture read data at the end of
  // ACCESS, and retire the grant into last_grant during ACK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= LAST_IDX;
      grant_q      <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata        <= '0;
    end else begin
      if (state_q == IDLE && arb_valid) begin
        grant_q <= arb_grant;
        write_q <= sel_write;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state_q == ACCESS && !write_q) rdata <= pio_readdata;
      if (state_q == ACK) last_grant_q <= grant_q;
    end
  end

  // Output logic
  always_comb begin
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_address    = '0;
    pio_writedata  = '0;
    ack            = '0;
    busy           = (state_q != IDLE);
    if (state_q == ACCESS) begin
      pio_chipselect = 1'b1;
      pio_write_n    = ~write_q;
      pio_address    = addr_q;
      pio_writedata  = wdata_q;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ack[i] = (state_q == ACK) && (32'(grant_q) == i);
    end
  end

endmodule

// File: tb/tb_pio_node_arbiter.sv
// Directed bench for pio_node_arbiter with a small PIO node model
// (register at address 0, other addresses ignore writes and read as 0).
module tb_pio_node_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  req_write;
  logic [1:0]  addr_a [4];
  logic [31:0] wd_a   [4];
  logic [7:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]  ack;
  logic [31:0] rdata;
  logic        busy;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic [31:0] node_reg = '0;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign req_addr  = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
  assign req_wdata = {wd_a[3], wd_a[2], wd_a[1], wd_a[0]};

  always @(posedge clk)
    if (pio_chipselect && !pio_write_n && pio_address == 2'd0)
      node_reg <= pio_writedata;
  assign pio_readdata = (pio_address == 2'd0) ? node_reg : 32'd0;

  pio_node_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (32),
    .ADDR_W  (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .ack            (ack),
    .rdata          (rdata),
    .busy           (busy),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_ack;
    reset_n   = 1'b0;
    req       = '0;
    req_write = '0;
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = '0;
      wd_a[i]   = '0;
    end
    #2;
    chk("rst_ack",   32'(ack), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_cs",    32'(pio_chipselect), 32'h0);
    chk("rst_wn",    32'(pio_write_n), 32'h1);
    chk("rst_addr",  32'(pio_address), 32'h0);
    chk("rst_wd",    pio_writedata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Single write by requester 1
    req_write[1] = 1'b1; addr_a[1] = 2'd0; wd_a[1] = 32'hDEADBEEF; req[1] = 1'b1;
    tick;
    chk("wr_cs",    32'(pio_chipselect), 32'h1);
    chk("wr_wn",    32'(pio_write_n), 32'h0);
    chk("wr_wd",    pio_writedata, 32'hDEADBEEF);
    chk("wr_ack0",  32'(ack), 32'h0);
    chk("wr_busy",  32'(busy), 32'h1);
    tick;
    chk("wr_cs_off", 32'(pio_chipselect), 32'h0);
    chk("wr_wn_off", 32'(pio_write_n), 32'h1);
    chk("wr_ack",    32'(ack), 32'h2);
    chk("wr_busy2",  32'(busy), 32'h1);
    req[1] = 1'b0;
    tick;
    chk("wr_idle_ack",  32'(ack), 32'h0);
    chk("wr_idle_busy", 32'(busy), 32'h0);

    // Read back by requester 2
    req_write[2] = 1'b0; addr_a[2] = 2'd0; req[2] = 1'b1;
    tick;
    chk("rd_cs",   32'(pio_chipselect), 32'h1);
    chk("rd_wn",   32'(pio_write_n), 32'h1);
    chk("rd_addr", 32'(pio_address), 32'h0);
    tick;
    chk("rd_ack",  32'(ack), 32'h4);
    chk("rd_data", rdata, 32'hDEADBEEF);
    req[2] = 1'b0;
    tick;

    // A write must not disturb rdata
    req_write[0] = 1'b1; addr_a[0] = 2'd0; wd_a[0] = 32'h12345678; req[0] = 1'b1;
    tick;
    tick;
    chk("hold_ack",   32'(ack), 32'h1);
    chk("hold_rdata", rdata, 32'hDEADBEEF);
    req[0] = 1'b0;
    tick;

    // Reset in the middle of a read by requester 3
    req_write[3] = 1'b0; addr_a[3] = 2'd0; req[3] = 1'b1;
    tick;
    chk("mr_cs_pre", 32'(pio_chipselect), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_cs",    32'(pio_chipselect), 32'h0);
    chk("mr_ack",   32'(ack), 32'h0);
    chk("mr_rdata", rdata, 32'h0);
    chk("mr_busy",  32'(busy), 32'h0);
    req[3] = 1'b0;
    repeat (2) tick;
    chk("mr_ack_hold",   32'(ack), 32'h0);
    chk("mr_rdata_hold", rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    addr_a[1] = 2'd1; addr_a[2] = 2'd2; req_write[1] = 1'b0; req_write[2] = 1'b0;
    req = 4'b0110;
    tick;
    chk("mr_addr1", 32'(pio_address), 32'h1);
    tick;
    chk("mr_g1", 32'(ack), 32'h2);
    req[1] = 1'b0;
    tick;
    tick;
    chk("mr_addr2", 32'(pio_address), 32'h2);
    tick;
    chk("mr_g2",     32'(ack), 32'h4);
    chk("mr_rdata2", rdata, 32'h0);
    req[2] = 1'b0;
    tick;

    // Write to a non-zero address passes through and is ignored by the node
    req_write[3] = 1'b1; addr_a[3] = 2'd3; wd_a[3] = 32'h0BADF00D; req[3] = 1'b1;
    tick;
    chk("fw_addr", 32'(pio_address), 32'h3);
    chk("fw_wd",   pio_writedata, 32'h0BADF00D);
    tick;
    chk("fw_ack3", 32'(ack), 32'h8);
    req[3] = 1'b0;
    tick;

    // Wrap: last grant 3, requesters 0 and 3 pending
    req_write[0] = 1'b0; addr_a[0] = 2'd0; req_write[3] = 1'b0; addr_a[3] = 2'd0;
    req = 4'b1001;
    tick;
    tick;
    chk("wrap_first", 32'(ack), 32'h1);
    chk("wrap_rdata", rdata, 32'h12345678);
    req[0] = 1'b0;
    tick;
    tick;
    tick;
    chk("wrap_second", 32'(ack), 32'h8);
    req[3] = 1'b0;
    tick;

    // Full contention, each requester drops on its ack
    req_write = '0;
    for (int i = 0; i < 4; i++) addr_a[i] = 2'd0;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_ack = 4'b0001 << k;
      tick;
      chk("ct_access_ack", 32'(ack), 32'h0);
      tick;
      chk("ct_ack", 32'(ack), 32'(exp_ack));
      req[k] = 1'b0;
      tick;
      chk("ct_idle_ack", 32'(ack), 32'h0);
    end
    chk("ct_busy_end", 32'(busy), 32'h0);

    // Inputs change during ACCESS: latched data still written
    req_write[2] = 1'b1; addr_a[2] = 2'd0; wd_a[2] = 32'hA5A5A5A5; req[2] = 1'b1;
    tick;
    wd_a[2] = 32'hFFFFFFFF; req[2] = 1'b0;
    #1;
    chk("ic_wd", pio_writedata, 32'hA5A5A5A5);
    tick;
    chk("ic_ack", 32'(ack), 32'h4);
    chk("ic_cs",  32'(pio_chipselect), 32'h0);
    tick;
    req_write[1] = 1'b0; addr_a[1] = 2'd0; req[1] = 1'b1;
    tick;
    tick;
    chk("ic_rb_ack",  32'(ack), 32'h2);
    chk("ic_readback", rdata, 32'hA5A5A5A5);
    req[1] = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pio_node_arbiter.md
PIO_NODE_ARBITER -- requirements
Module: pio_node_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one PIO node slave.
REQ-002 The block SHALL have parameter DATA_W, default 32: PIO data width.
REQ-003 The block SHALL have parameter ADDR_W, default 2: PIO register address width.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester access request, held until ack.
REQ-007 The block SHALL have port req_write, input, NUM_REQ bits: per-requester direction, 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, NUM_REQ*ADDR_W bits: packed per-requester addresses, requester i at slice i.
REQ-009 The block SHALL have port req_wdata, input, NUM_REQ*DATA_W bits: packed per-requester write data.
REQ-010 The block SHALL have port ack, output, NUM_REQ bits: one-cycle completion pulse to the granted requester.
REQ-011 The block SHALL have port rdata, output, DATA_W bits: data from the last completed read.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 The block SHALL have ports pio_address (out, ADDR_W), pio_chipselect (out, 1), pio_write_n (out, 1) and pio_writedata (out, DATA_W): Avalon slave drive to the PIO node.
REQ-014 The block SHALL have port pio_readdata, input, DATA_W bits: PIO combinational read data.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS and ACK; each transaction takes exactly 3 cycles (IDLE->ACCESS->ACK->IDLE).
REQ-016 In IDLE with any req bit high, the block SHALL grant round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-017 On grant, the block SHALL latch the grant index, req_write, req_addr slice and req_wdata slice, then enter ACCESS.
REQ-018 In IDLE with req all zero, the block SHALL remain in IDLE.
REQ-019 In ACCESS, the block SHALL drive pio_chipselect=1, pio_write_n=~latched write, and pio_address and pio_writedata from latched values, for exactly one cycle.
REQ-020 Outside ACCESS, the block SHALL drive pio_chipselect=0, pio_write_n=1, pio_address=0 and pio_writedata=0.
REQ-021 For a read in ACCESS, the block SHALL register pio_readdata into rdata at the end of that cycle; rdata SHALL hold until the next read completes and be unaffected by writes.
REQ-022 In ACK, the block SHALL pulse ack[grant]=1 for one cycle with all other ack bits 0, update last_grant to grant, then return to IDLE.
REQ-023 Latency: with req sampled at edge N in IDLE, ACCESS SHALL occupy cycle N+1 and ack SHALL be high in cycle N+2.
REQ-024 A requester SHALL deassert req at the edge where it samples ack=1; a req still high in the following IDLE SHALL be treated as a new request.
REQ-025 Once latched, a transaction SHALL complete even if req or its inputs change during ACCESS or ACK.
REQ-026 Simultaneous requests SHALL be served one per transaction in rotating order, with no requester waiting more than NUM_REQ transactions.
REQ-027 Addresses other than 0 SHALL be passed through unmodified (the node ignores writes and returns 0 on reads).

Reset
REQ-028 While reset_n=0, the block SHALL force state=IDLE, ack=0, rdata=0, busy=0, pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0 and last_grant=NUM_REQ-1, asynchronously.
REQ-029 Reset asserted during ACCESS or ACK SHALL abort the transaction with no ack and no rdata update.
REQ-030 After reset, requester 0 SHALL have first priority.

Structure
REQ-031 Package pio_arb_pkg SHALL hold the state enum (IDLE, ACCESS, ACK) and the default parameter constants.
REQ-032 Round-robin selection SHALL be implemented as sub-module rr_arbiter, with inputs req and last_grant and outputs grant index and valid.

Verification
REQ-033 Single write: req[1]=1, write, addr 0, wdata 0xDEADBEEF -> chipselect=1 and write_n=0 for exactly one cycle with writedata 0xDEADBEEF; ack[1] pulses 2 cycles after the sampling edge.
REQ-034 Read-back: after REQ-033, req[2] read at addr 0 with pio_readdata=0xDEADBEEF -> rdata=0xDEADBEEF during ack[2], held through a subsequent write.
REQ-035 Contention: req=4'b1111 held, each requester dropping req on its ack -> ack order 0,1,2,3, each spaced 3 cycles apart.
REQ-036 Fairness wrap: last grant 3, req=4'b1001 -> requester 0 granted, then requester 3.
REQ-037 Mid-operation reset: reset_n low during ACCESS -> chipselect drops immediately, no ack, rdata=0; after release, req=4'b0110 -> requester 1 granted first.
REQ-038 Input change: req_wdata changed and req dropped during ACCESS -> originally latched data is written and ack still pulses.
